vga_poll_scanner: RTL and testbench

// Raster master for the pixel-poll interface. Generates 640x480@60 VGA timing from a

---
 rtl/vga_poll_scanner.sv | 122 ++++++++++++
 tb/tb_vga_poll_scanner.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_poll_scanner.sv
// ---------------------------------------------------------------------------
// vga_poll_scanner
//
// Raster master for the pixel-poll interface. A clock divider produces one
// pixel tick every CLK_DIV clocks; horizontal/vertical counters advance on that
// tick and are presented as (poll_x, poll_y) to the hit-test responders. The
// OR-ed hit return is sampled on the tick cycle only, so any responder that
// settles within HIT_LAT (< CLK_DIV) clocks is seen correctly. Colour and
// sync are registered together on the tick, one pixel period behind the poll.
//
// Ports
//   clk          in   system clock
//   reset        in   synchronous, active-high
//   poll_x       out  [9:0] column being polled (0 outside the active area)
//   poll_y       out  [8:0] row being polled (0 outside the active area)
//   poll_valid   out  high while the poll lies in the active area
//   hit          in   OR of all responder hits for the current poll
//   vga_hs       out  horizontal sync, active low
//   vga_vs       out  vertical sync, active low
//   vga_rgb      out  [7:0] RGB332 pixel
//   frame_start  out  one-clk pulse on the tick cycle of pixel (0,0)
// ---------------------------------------------------------------------------
module vga_poll_scanner #(
  parameter int         CLK_DIV  = 4,
  parameter int         HIT_LAT  = 1,
  parameter int         H_ACTIVE = 640,
  parameter int         H_FP     = 16,
  parameter int         H_SYNC   = 96,
  parameter int         H_BP     = 48,
  parameter int         V_ACTIVE = 480,
  parameter int         V_FP     = 10,
  parameter int         V_SYNC   = 2,
  parameter int         V_BP     = 33,
  parameter logic [7:0] FG_COLOR = 8'hFF,
  parameter logic [7:0] BG_COLOR = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] poll_x,
  output logic [8:0] poll_y,
  output logic       poll_valid,
  input  logic       hit,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic [7:0] vga_rgb,
  output logic       frame_start
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  // The hit sample point relies on the responder settling before the tick.
  generate
    if (CLK_DIV < 2 || HIT_LAT >= CLK_DIV) begin : gBadParams
      $error("vga_poll_scanner: need CLK_DIV >= 2 and HIT_LAT < CLK_DIV");
    end
  endgenerate

  logic [DIV_W-1:0] divCnt, divNext;
  logic [9:0]       hCnt, hNext;
  logic [9:0]       vCnt, vNext;
  logic             tick;
  logic             active;
  logic             activeNext;

  always_comb begin
    tick    = (divCnt == DIV_LAST);
    divNext = tick ? '0 : divCnt + 1'b1;
    hNext   = hCnt;
    vNext   = vCnt;
    if (tick) begin
      if (hCnt == H_LAST) begin
        hNext = '0;
        vNext = (vCnt == V_LAST) ? '0 : vCnt + 10'd1;
      end else begin
        hNext = hCnt + 10'd1;
      end
    end
    active     = (hCnt < H_ACT) && (vCnt < V_ACT);
    activeNext = (hNext < H_ACT) && (vNext < V_ACT);
  end

  assign poll_x = active ? hCnt : '0;
  assign poll_y = active ? vCnt[8:0] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      divCnt      <= '0;
      hCnt        <= '0;
      vCnt        <= '0;
      poll_valid  <= 1'b0;
      frame_start <= 1'b0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_rgb     <= 8'h00;
    end else begin
      divCnt <= divNext;
      hCnt   <= hNext;
      vCnt   <= vNext;
      // Registered from next-state values so poll_valid tracks the counters
      // without a lag, yet reads 0 for the clock that follows a reset edge.
      poll_valid  <= activeNext;
      // High during the tick cycle of pixel (0,0): predict it one clock early.
      frame_start <= (divNext == DIV_LAST) && (hNext == 10'd0) && (vNext == 10'd0);
      if (tick) begin
        vga_rgb <= active ? (hit ? FG_COLOR : BG_COLOR) : 8'h00;
        vga_hs  <= ~((hCnt >= HS_START) && (hCnt < HS_END));
        vga_vs  <= ~((vCnt >= VS_START) && (vCnt < VS_END));
      end
    end
  end

endmodule

// File: tb/tb_vga_poll_scanner.sv
// ---------------------------------------------------------------------------
// tb_vga_poll_scanner
//
// Drives the scanner with a reduced raster (24x18 total, 16x12 visible,
// CLK_DIV=4) so full frames fit in a short run. A model derives every output
// from the number of clocks since reset; directed scenarios add hand-computed
// frame totals and reset-recovery values.
// ---------------------------------------------------------------------------
module tb_vga_poll_scanner;

  localparam int D    = 4;
  localparam int HA   = 16;
  localparam int HFP  = 2;
  localparam int HSW  = 3;
  localparam int HBP  = 3;
  localparam int VA   = 12;
  localparam int VFP  = 2;
  localparam int VSW  = 2;
  localparam int VBP  = 2;
  localparam int HT   = HA + HFP + HSW + HBP;  // 24
  localparam int VT   = VA + VFP + VSW + VBP;  // 18
  localparam int FT   = HT * VT;               // 432 pixels
  localparam int FCLK = FT * D;                // 1728 clocks

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       hit = 1'b0;
  logic [9:0] poll_x;
  logic [8:0] poll_y;
  logic       poll_valid;
  logic       vga_hs;
  logic       vga_vs;
  logic [7:0] vga_rgb;
  logic       frame_start;

  vga_poll_scanner #(
    .CLK_DIV(D), .HIT_LAT(3),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .FG_COLOR(8'hFF), .BG_COLOR(8'h00)
  ) dut (
    .clk(clk), .reset(reset),
    .poll_x(poll_x), .poll_y(poll_y), .poll_valid(poll_valid),
    .hit(hit),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_rgb(vga_rgb),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int n = 0;          // clocks since the last reset edge
  bit chkEn = 1'b0;
  int mode = 0;       // 0: no hit, 1: 4-pixel window, 2: hit tied high
  int lat = 1;
  bit glitchEn = 1'b0;
  bit hist [0:3];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (n=%0d)", name, act, exp, n);
    end
  endtask

  function automatic bit windowHit(input int x, input int y);
    return (x >= 5) && (x <= 8) && (y == 3);
  endfunction

  function automatic bit modeHit(input int x, input int y);
    if (mode == 2) return 1'b1;
    if (mode == 1) return windowHit(x, y);
    return 1'b0;
  endfunction

  function automatic bit inActive(input int x, input int y);
    return (x < HA) && (y < VA);
  endfunction

  // Model: everything follows from n. Pixel index = n / D; the output stage
  // shows the previous pixel, and shows reset values before the first tick.
  task automatic compareModel();
    int q, p, h, v, qp, hp, vp;
    bit act;
    q   = n / D;
    p   = q % FT;
    h   = p % HT;
    v   = p / HT;
    act = inActive(h, v);
    check("poll_x", int'(poll_x), act ? h : 0);
    check("poll_y", int'(poll_y), act ? v : 0);
    check("poll_valid", int'(poll_valid), int'((n != 0) && act));
    check("frame_start", int'(frame_start), int'((n % D == D - 1) && (p == 0)));
    if (q == 0) begin
      check("vga_rgb", int'(vga_rgb), 0);
      check("vga_hs", int'(vga_hs), 1);
      check("vga_vs", int'(vga_vs), 1);
    end else begin
      qp = (q - 1) % FT;
      hp = qp % HT;
      vp = qp / HT;
      check("vga_rgb", int'(vga_rgb), (inActive(hp, vp) && modeHit(hp, vp)) ? 255 : 0);
      check("vga_hs", int'(vga_hs), int'(!((hp >= HA + HFP) && (hp < HA + HFP + HSW))));
      check("vga_vs", int'(vga_vs), int'(!((vp >= VA + VFP) && (vp < VA + VFP + VSW))));
    end
  endtask

  // Compare process: update the clock count, then check all outputs.
  always @(posedge clk) begin : monitor
    bit r;
    r = reset;
    #1;
    if (r) n = 0;
    else n = n + 1;
    if (chkEn) compareModel();
  end

  // Responder model: hit follows the poll after lat clocks; optional random
  // glitches land only on cycles that are not the sampling tick.
  always @(posedge clk) begin : responder
    #2;
    for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
    if (mode == 2) hist[0] = 1'b1;
    else if (mode == 1) hist[0] = windowHit(int'(poll_x), int'(poll_y));
    else hist[0] = 1'b0;
    hit = hist[lat] | (glitchEn && (n % D != D - 1) && ($urandom_range(0, 1) == 1));
  end

  // Pulse reset for one edge and switch scenario; returns at n = 0.
  task automatic doReset(input int m, input int l, input bit g);
    @(posedge clk); #3;
    reset = 1'b1;
    mode = m; lat = l; glitchEn = g;
    @(posedge clk); #3;
    reset = 1'b0;
  endtask

  task automatic measure(input int cycles, output int hsLow, output int vsLow,
                         output int fg, output int pvHigh, output int fsCnt,
                         output int fsFirst, output int fsLast);
    hsLow = 0; vsLow = 0; fg = 0; pvHigh = 0; fsCnt = 0; fsFirst = -1; fsLast = -1;
    for (int i = 0; i < cycles; i++) begin
      if (i > 0) begin
        @(posedge clk); #3;
      end
      if (!vga_hs) hsLow++;
      if (!vga_vs) vsLow++;
      if (vga_rgb == 8'hFF) fg++;
      if (poll_valid) pvHigh++;
      if (frame_start) begin
        fsCnt++;
        if (fsFirst < 0) fsFirst = i;
        fsLast = i;
      end
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int hsLow, vsLow, fg, pvHigh, fsCnt, fsFirst, fsLast;
    int waited;

    // Power-up reset, then reset-state literals at n = 0.
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b0;
    chkEn = 1'b1;
    check("reset poll_x", int'(poll_x), 0);
    check("reset poll_y", int'(poll_y), 0);
    check("reset poll_valid", int'(poll_valid), 0);
    check("reset vga_hs", int'(vga_hs), 1);
    check("reset vga_vs", int'(vga_vs), 1);
    check("reset vga_rgb", int'(vga_rgb), 0);
    check("reset frame_start", int'(frame_start), 0);
    $display("reset state checked");

    // Timing over two frames, hit never asserted.
    measure(2 * FCLK, hsLow, vsLow, fg, pvHigh, fsCnt, fsFirst, fsLast);
    check("first frame_start clk", fsFirst, 3);
    check("frame_start period", fsLast - fsFirst, 1728);
    check("frame_start count", fsCnt, 2);
    check("hsync low clks", hsLow, 432);
    check("vsync low clks", vsLow, 384);
    check("poll_valid clks", pvHigh, 1535);
    check("fg clks no hit", fg, 0);
    $display("timing: hs=%0d vs=%0d pv=%0d fs_first=%0d", hsLow, vsLow, pvHigh, fsFirst);

    // Window responder, 1-clk latency.
    doReset(1, 1, 1'b0);
    measure(FCLK, hsLow, vsLow, fg, pvHigh, fsCnt, fsFirst, fsLast);
    check("fg clks window lat1", fg, 16);
    $display("window lat1: fg clks=%0d", fg);

    // Same window, 3-clk latency and off-tick glitches.
    doReset(1, 3, 1'b1);
    measure(FCLK, hsLow, vsLow, fg, pvHigh, fsCnt, fsFirst, fsLast);
    check("fg clks window lat3 glitch", fg, 16);
    $display("window lat3 glitch: fg clks=%0d", fg);

    // Hit tied high: colour only inside the visible area.
    doReset(2, 1, 1'b0);
    measure(FCLK, hsLow, vsLow, fg, pvHigh, fsCnt, fsFirst, fsLast);
    check("fg clks hit tied", fg, 768);
    check("poll_valid clks hit tied", pvHigh, 767);
    $display("hit tied: fg clks=%0d pv clks=%0d", fg, pvHigh);

    // Mid-frame reset at pixel (10,5): index 130, second clock of that pixel.
    doReset(2, 1, 1'b0);
    waited = 0;
    while (n != D * 130 + 1 && waited < 2 * FCLK) begin
      @(posedge clk); #3;
      waited++;
    end
    check("pre-reset poll_x", int'(poll_x), 10);
    check("pre-reset poll_y", int'(poll_y), 5);
    check("pre-reset vga_rgb", int'(vga_rgb), 255);
    reset = 1'b1;
    @(posedge clk); #3;
    reset = 1'b0;
    check("mid reset poll_x", int'(poll_x), 0);
    check("mid reset poll_y", int'(poll_y), 0);
    check("mid reset poll_valid", int'(poll_valid), 0);
    check("mid reset vga_hs", int'(vga_hs), 1);
    check("mid reset vga_vs", int'(vga_vs), 1);
    check("mid reset vga_rgb", int'(vga_rgb), 0);
    measure(8, hsLow, vsLow, fg, pvHigh, fsCnt, fsFirst, fsLast);
    check("frame_start after mid reset", fsFirst, 3);
    $display("mid-frame reset: frame_start at clk %0d", fsFirst);

    @(posedge clk); #3;
    chkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
